// File: rtl/jump_judge.sv
// jump_judge: latches a released charge, animates the jump on tick, then judges the
// landing against the per-direction target and keeps score. Option: JUMP_JUDGE_BONUS_EN.
module jump_judge #(
  parameter int unsigned STEP      = 4,
  parameter int unsigned TOL       = 3,
  parameter int unsigned TGT_UP    = 16,
  parameter int unsigned TGT_DOWN  = 24,
  parameter int unsigned TGT_LEFT  = 32,
  parameter int unsigned TGT_RIGHT = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       is_pressing,
  input  logic [3:0] press_time,
  input  logic [1:0] position,
  input  logic       restart,
  output logic       jump_active,
  output logic [1:0] jump_dir,
  output logic [7:0] jump_offset,
  output logic       get_score,
  output logic [7:0] score,
  output logic       game_end
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHARGE = 3'd1,
    FLIGHT = 3'd2,
    JUDGE  = 3'd3,
    OVER   = 3'd4
  } state_t;

  state_t      state_r, state_n_s;
  logic        pr_d_r;
  logic [3:0]  pt_r;
  logic [3:0]  cnt_r;
  logic [7:0]  dist_r;
  logic        rise_s;
  logic        step_s;
  logic        hit_s;
  logic [7:0]  tgt_s;
  logic [8:0]  diff_s;
  logic [1:0]  inc_s;

  function automatic logic [7:0] target_of(input logic [1:0] dir);
    case (dir)
      2'b00:   target_of = 8'(TGT_UP);
      2'b01:   target_of = 8'(TGT_DOWN);
      2'b10:   target_of = 8'(TGT_LEFT);
      2'b11:   target_of = 8'(TGT_RIGHT);
      default: target_of = 8'd0;
    endcase
  endfunction

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, a} + {7'd0, inc};
    sat_add = sum[8] ? 8'hFF : sum[7:0];
  endfunction

  // Next-state, flight stepping and landing judgement.
  always_comb begin
    state_n_s = state_r;
    rise_s    = is_pressing & ~pr_d_r;
    step_s    = 1'b0;
    get_score = 1'b0;
    tgt_s     = target_of(jump_dir);
    if (dist_r >= tgt_s) begin
      diff_s = {1'b0, dist_r - tgt_s};
    end else begin
      diff_s = {1'b0, tgt_s - dist_r};
    end
    hit_s = (diff_s <= 9'(TOL));
`ifdef JUMP_JUDGE_BONUS_EN
    inc_s = (diff_s == 9'd0) ? 2'd2 : 2'd1;
`else
    inc_s = 2'd1;
`endif
    case (state_r)
      IDLE: begin
        if (rise_s) state_n_s = CHARGE;
        else        state_n_s = IDLE;
      end
      CHARGE: begin
        if (!is_pressing) state_n_s = FLIGHT;
        else              state_n_s = CHARGE;
      end
      FLIGHT: begin
        step_s = tick && (cnt_r < pt_r);
        // Leave on the edge that consumes the last tick, or at once when pt is zero.
        if ((cnt_r == pt_r) || (step_s && ((cnt_r + 4'd1) == pt_r))) state_n_s = JUDGE;
        else                                                         state_n_s = FLIGHT;
      end
      JUDGE: begin
        get_score = hit_s;
        if (hit_s) state_n_s = IDLE;
        else       state_n_s = OVER;
      end
      OVER: begin
        if (restart) state_n_s = IDLE;
        else         state_n_s = OVER;
      end
      default: state_n_s = IDLE;
    endcase
  end

  // State, latched jump parameters, flight progress and score.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      pr_d_r      <= 1'b0;
      pt_r        <= 4'd0;
      cnt_r       <= 4'd0;
      dist_r      <= 8'd0;
      jump_active <= 1'b0;
      jump_dir    <= 2'd0;
      jump_offset <= 8'd0;
      score       <= 8'd0;
      game_end    <= 1'b0;
    end else begin
      state_r     <= state_n_s;
      pr_d_r      <= is_pressing;
      jump_active <= (state_n_s == FLIGHT);
      game_end    <= (state_n_s == OVER);
      if ((state_r == CHARGE) && !is_pressing) begin
        pt_r        <= press_time;
        jump_dir    <= position;
        dist_r      <= 8'(press_time) * 8'(STEP);
        jump_offset <= 8'd0;
        cnt_r       <= 4'd0;
      end else if (step_s) begin
        jump_offset <= jump_offset + 8'(STEP);
        cnt_r       <= cnt_r + 4'd1;
      end else if ((state_r == OVER) && restart) begin
        jump_offset <= 8'd0;
        jump_dir    <= 2'd0;
      end
      if ((state_r == JUDGE) && hit_s) begin
        score <= sat_add(score, inc_s);
      end else if ((state_r == OVER) && restart) begin
        score <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_jump_judge.sv
// Self-checking bench for jump_judge: directed table, hand-written corner sequences
// and randomized jumps checked against a jump-level scoring model.
module tb_jump_judge;

`ifdef JUMP_JUDGE_BONUS_EN
  localparam int BONUS = 1;
`else
  localparam int BONUS = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       is_pressing = 1'b0;
  logic [3:0] press_time = 4'd0;
  logic [1:0] position = 2'd0;
  logic       restart = 1'b0;
  logic       jump_active, get_score, game_end;
  logic [1:0] jump_dir;
  logic [7:0] jump_offset, score;
  logic       ja_t4, gs_t4, ge_t4;
  logic [1:0] dir_t4;
  logic [7:0] off_t4, score_t4;

  int errors = 0;
  int checks = 0;
  int exp_score = 0;
  int gs_cnt = 0;
  int gs4_cnt = 0;
  int ja_rise = 0;
  logic ja_prev = 1'b0;
  int offs[$];

  jump_judge dut (
    .clk(clk), .rst(rst), .tick(tick), .is_pressing(is_pressing),
    .press_time(press_time), .position(position), .restart(restart),
    .jump_active(jump_active), .jump_dir(jump_dir), .jump_offset(jump_offset),
    .get_score(get_score), .score(score), .game_end(game_end)
  );

  jump_judge #(.TOL(4)) dut_t4 (
    .clk(clk), .rst(rst), .tick(tick), .is_pressing(is_pressing),
    .press_time(press_time), .position(position), .restart(restart),
    .jump_active(ja_t4), .jump_dir(dir_t4), .jump_offset(off_t4),
    .get_score(gs_t4), .score(score_t4), .game_end(ge_t4)
  );

  always #5 clk = ~clk;

  // Pulse and flight-start counters sampled away from the active edge.
  always @(negedge clk) begin
    ja_prev <= jump_active;
    if (get_score) gs_cnt <= gs_cnt + 1;
    if (gs_t4) gs4_cnt <= gs4_cnt + 1;
    if (jump_active && !ja_prev) ja_rise <= ja_rise + 1;
  end

  function automatic int tgt_of(input int pos);
    case (pos)
      0: return 16;
      1: return 24;
      2: return 32;
      default: return 40;
    endcase
  endfunction

  function automatic int absdiff(input int pt, input int pos);
    int d;
    d = pt * 4 - tgt_of(pos);
    return (d < 0) ? -d : d;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic press_release(input int pt, input int pos);
    @(negedge clk);
    press_time  = 4'(pt);
    position    = 2'(pos);
    is_pressing = 1'b1;
    @(negedge clk);
    @(negedge clk);
    is_pressing = 1'b0;
  endtask

  task automatic fly(input int pct, output int timeout);
    int n;
    logic [7:0] last;
    timeout = 0;
    n = 0;
    while (!jump_active && n < 6) begin
      @(negedge clk);
      n++;
    end
    if (!jump_active) timeout = 1;
    offs.delete();
    last = jump_offset;
    n = 0;
    while (jump_active && n < 400) begin
      tick = ($urandom_range(99) < pct);
      @(negedge clk);
      n++;
      if (jump_offset != last) begin
        offs.push_back(int'(jump_offset));
        last = jump_offset;
      end
    end
    if (jump_active) timeout = 1;
    tick = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic jump_and_check(input string nm, input int pt, input int pos, input int pct,
                                input int eoff, input bit ehit, input bit ehit4);
    int g0, g40, to, d;
    g0  = gs_cnt;
    g40 = gs4_cnt;
    press_release(pt, pos);
    fly(pct, to);
    d = absdiff(pt, pos);
    if (ehit) begin
      exp_score = exp_score + ((BONUS != 0 && d == 0) ? 2 : 1);
      if (exp_score > 255) exp_score = 255;
    end
    check({nm, " timeout"}, to, 0);
    check({nm, " offset"}, jump_offset, eoff);
    check({nm, " dir"}, jump_dir, pos);
    check({nm, " get_score pulses"}, gs_cnt - g0, ehit ? 1 : 0);
    check({nm, " tol4 pulses"}, gs4_cnt - g40, ehit4 ? 1 : 0);
    check({nm, " game_end"}, game_end, ehit ? 0 : 1);
    check({nm, " score"}, score, exp_score);
    if (!ehit) begin
      @(negedge clk) restart = 1'b1;
      @(negedge clk) restart = 1'b0;
      exp_score = 0;
      check({nm, " restart game_end"}, game_end, 0);
      check({nm, " restart score"}, score, 0);
      check({nm, " restart offset"}, jump_offset, 0);
      check({nm, " restart dir"}, jump_dir, 0);
    end
  endtask

  typedef struct {
    int pt;
    int pos;
    int off;
    bit hit;
    bit hit4;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int to, g0, r0, n, pt, pos, d;
    tbl[0]  = '{4,  0, 16, 1'b1, 1'b1};
    tbl[1]  = '{6,  1, 24, 1'b1, 1'b1};
    tbl[2]  = '{8,  2, 32, 1'b1, 1'b1};
    tbl[3]  = '{10, 3, 40, 1'b1, 1'b1};
    tbl[4]  = '{5,  0, 20, 1'b0, 1'b1};
    tbl[5]  = '{9,  1, 36, 1'b0, 1'b0};
    tbl[6]  = '{0,  0, 0,  1'b0, 1'b0};
    tbl[7]  = '{7,  2, 28, 1'b0, 1'b1};
    tbl[8]  = '{9,  2, 36, 1'b0, 1'b1};
    tbl[9]  = '{11, 3, 44, 1'b0, 1'b1};
    tbl[10] = '{3,  0, 12, 1'b0, 1'b1};
    tbl[11] = '{15, 3, 60, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    check("reset jump_active", jump_active, 0);
    check("reset jump_dir", jump_dir, 0);
    check("reset jump_offset", jump_offset, 0);
    check("reset get_score", get_score, 0);
    check("reset score", score, 0);
    check("reset game_end", game_end, 0);
    rst = 1'b0;

    // Hit on up with the offset stepping one STEP per tick.
    jump_and_check("hit_up", 4, 0, 100, 16, 1'b1, 1'b1);
    check("hit_up steps", offs.size(), 4);
    for (int i = 0; i < offs.size() && i < 4; i++) check("hit_up step value", offs[i], 4 * (i + 1));

    // Miss, then a press during OVER must not start a flight.
    press_release(9, 1);
    fly(100, to);
    check("over timeout", to, 0);
    check("over game_end", game_end, 1);
    r0 = ja_rise;
    press_release(4, 0);
    repeat (8) @(negedge clk);
    check("over press ignored", ja_rise - r0, 0);
    check("over game_end held", game_end, 1);
    check("over score held", score, exp_score);
    @(negedge clk) restart = 1'b1;
    @(negedge clk) restart = 1'b0;
    exp_score = 0;
    check("over restart game_end", game_end, 0);
    check("over restart score", score, 0);

    for (int i = 0; i < 12; i++) begin
      jump_and_check("table", tbl[i].pt, tbl[i].pos, 60, tbl[i].off, tbl[i].hit, tbl[i].hit4);
    end

    // Restart outside OVER is ignored.
    jump_and_check("pre_restart", 4, 0, 100, 16, 1'b1, 1'b1);
    @(negedge clk) restart = 1'b1;
    @(negedge clk) restart = 1'b0;
    check("idle restart score", score, exp_score);
    check("idle restart offset", jump_offset, 16);

    // Press raised during FLIGHT and held into IDLE is stale.
    g0 = gs_cnt;
    r0 = ja_rise;
    press_release(4, 0);
    @(negedge clk) is_pressing = 1'b1;
    fly(100, to);
    repeat (5) @(negedge clk);
    is_pressing = 1'b0;
    repeat (6) @(negedge clk);
    exp_score = exp_score + ((BONUS != 0) ? 2 : 1);
    check("stale timeout", to, 0);
    check("stale one flight", ja_rise - r0, 1);
    check("stale one pulse", gs_cnt - g0, 1);
    check("stale score", score, exp_score);
    jump_and_check("after_stale", 6, 1, 100, 24, 1'b1, 1'b1);

    for (int k = 0; k < 40; k++) begin
      pt  = $urandom_range(15);
      pos = $urandom_range(3);
      d   = absdiff(pt, pos);
      jump_and_check("random", pt, pos, $urandom_range(100, 30), pt * 4, d <= 3, d <= 4);
    end

    // Saturation: keep hitting until the model reaches 255, then two more.
    n = 0;
    for (int k = 0; k < 300; k++) begin
      if (exp_score == 255) n++;
      if (n > 2) break;
      jump_and_check("sat", 4, 0, 100, 16, 1'b1, 1'b1);
    end
    check("sat final score", score, 255);

    // Asynchronous reset in the middle of a flight.
    press_release(8, 2);
    n = 0;
    while (!jump_active && n < 6) begin
      @(negedge clk);
      n++;
    end
    check("rst flight started", jump_active, 1);
    tick = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async jump_active", jump_active, 0);
    check("async jump_dir", jump_dir, 0);
    check("async jump_offset", jump_offset, 0);
    check("async get_score", get_score, 0);
    check("async score", score, 0);
    check("async game_end", game_end, 0);
    g0 = gs_cnt;
    @(negedge clk) rst = 1'b0;
    repeat (15) @(negedge clk);
    tick = 1'b0;
    check("post reset pulses", gs_cnt - g0, 0);
    check("post reset score", score, 0);
    check("post reset active", jump_active, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
